// File: rtl/gemm_tile_issuer_pkg.sv
// Shared configuration for the GEMM tile issuer:
// array dimensions, tile limits, FSM states and descriptor layout.
package gemm_tile_issuer_pkg;

  localparam int SMALL_SYS_ROWS = 16;
  localparam int SMALL_SYS_COLS = 16;
  localparam int CFG_DIM_W      = 16;
  localparam int CFG_TILE_K     = SMALL_SYS_ROWS;
  localparam int CFG_TILE_N     = SMALL_SYS_COLS;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } tile_state_e;

  typedef struct packed {
    logic [4:0]           ksize;
    logic [4:0]           nsize;
    logic [CFG_DIM_W-1:0] k_off;
    logic [CFG_DIM_W-1:0] n_off;
    logic                 k_last;
    logic                 n_last;
  } tile_desc_t;

endpackage

// File: rtl/gemm_tile_issuer_tile_dim_counter.sv
// One tiling dimension: offset register, remainder, clamped size, last flag.
// Outputs reflect the next-cycle offset so the top can register them.
module tile_dim_counter
  import gemm_tile_issuer_pkg::*;
#(
  parameter int DIM_W = CFG_DIM_W,
  parameter int TILE  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIM_W-1:0] total,
  input  logic             step,
  input  logic             clr,
  output logic [DIM_W-1:0] off_nxt,
  output logic [4:0]       size_nxt,
  output logic             last_nxt
);

  logic [DIM_W-1:0] tot_q, tot_d;
  logic [DIM_W-1:0] off_q, off_d;
  logic [DIM_W:0]   rem;

  always_comb begin
    tot_d = tot_q;
    off_d = off_q;
    if (load) begin
      tot_d = total;
      off_d = '0;
    end else if (clr) begin
      off_d = '0;
    end else if (step) begin
      off_d = off_q + DIM_W'(TILE);
    end
  end

  // Extra bit keeps the remainder from wrapping.
  always_comb begin
    rem      = {1'b0, tot_d} - {1'b0, off_d};
    last_nxt = rem <= (DIM_W+1)'(TILE);
    size_nxt = last_nxt ? rem[4:0] : 5'(TILE);
    off_nxt  = off_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tot_q <= '0;
      off_q <= '0;
    end else begin
      tot_q <= tot_d;
      off_q <= off_d;
    end
  end

endmodule

// File: rtl/gemm_tile_issuer.sv
// Walks a K x N GEMM job in tiles (K inner loop) and
// issues one registered descriptor per tile over valid/ready.
module gemm_tile_issuer
  import gemm_tile_issuer_pkg::*;
#(
  parameter int DIM_W  = CFG_DIM_W,
  parameter int TILE_K = CFG_TILE_K,
  parameter int TILE_N = CFG_TILE_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] k_total,
  input  logic [DIM_W-1:0] n_total,
  output logic             busy,
  output logic             tile_valid,
  input  logic             tile_ready,
  output logic [4:0]       ksize,
  output logic [4:0]       nsize,
  output logic [DIM_W-1:0] k_off,
  output logic [DIM_W-1:0] n_off,
  output logic             k_last,
  output logic             n_last,
  output logic             done
);

  tile_state_e state_q, state_d;
  tile_desc_t  desc_q, desc_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;

  logic             load, xfer;
  logic             k_step, k_clr, n_step;
  logic [DIM_W-1:0] k_off_nxt, n_off_nxt;
  logic [4:0]       k_size_nxt, n_size_nxt;
  logic             k_last_nxt, n_last_nxt;

  tile_dim_counter #(.DIM_W(DIM_W), .TILE(TILE_K)) u_k_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .total    (k_total),
    .step     (k_step),
    .clr      (k_clr),
    .off_nxt  (k_off_nxt),
    .size_nxt (k_size_nxt),
    .last_nxt (k_last_nxt)
  );

  tile_dim_counter #(.DIM_W(DIM_W), .TILE(TILE_N)) u_n_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .total    (n_total),
    .step     (n_step),
    .clr      (1'b0),
    .off_nxt  (n_off_nxt),
    .size_nxt (n_size_nxt),
    .last_nxt (n_last_nxt)
  );

  always_comb begin
    xfer    = valid_q && tile_ready;
    state_d = state_q;
    load    = 1'b0;
    k_step  = 1'b0;
    k_clr   = 1'b0;
    n_step  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (k_total == '0 || n_total == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (xfer) begin
          if (!desc_q.k_last) begin
            k_step = 1'b1;
          end else if (!desc_q.n_last) begin
            k_clr  = 1'b1;
            n_step = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stalled ISSUE leaves the counters untouched, so desc_d holds.
  always_comb begin
    busy_d  = state_d == ISSUE;
    valid_d = state_d == ISSUE;
    done_d  = state_d == DONE;
    desc_d  = '0;
    if (state_d == ISSUE) begin
      desc_d.ksize  = k_size_nxt;
      desc_d.nsize  = n_size_nxt;
      desc_d.k_off  = k_off_nxt;
      desc_d.n_off  = n_off_nxt;
      desc_d.k_last = k_last_nxt;
      desc_d.n_last = n_last_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      desc_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      desc_q  <= desc_d;
    end
  end

  assign busy       = busy_q;
  assign tile_valid = valid_q;
  assign done       = done_q;
  assign ksize      = desc_q.ksize;
  assign nsize      = desc_q.nsize;
  assign k_off      = desc_q.k_off;
  assign n_off      = desc_q.n_off;
  assign k_last     = desc_q.k_last;
  assign n_last     = desc_q.n_last;

endmodule

// File: tb/tb_gemm_tile_issuer.sv
// Self-checking bench for gemm_tile_issuer with a descriptor
// scoreboard filled from a reference tiling loop.
module tb_gemm_tile_issuer;
  import gemm_tile_issuer_pkg::*;

  localparam int TK = 16;
  localparam int TN = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] k_total, n_total;
  logic        busy, tile_valid, tile_ready;
  logic [4:0]  ksize, nsize;
  logic [15:0] k_off, n_off;
  logic        k_last, n_last, done;

  int checks = 0;
  int errors = 0;
  int n_xfer = 0;
  tile_desc_t sb[$];

  always #5 clk = ~clk;

  gemm_tile_issuer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .k_total    (k_total),
    .n_total    (n_total),
    .busy       (busy),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .ksize      (ksize),
    .nsize      (nsize),
    .k_off      (k_off),
    .n_off      (n_off),
    .k_last     (k_last),
    .n_last     (n_last),
    .done       (done)
  );

  function automatic void push_job(int k, int n);
    tile_desc_t d;
    for (int no = 0; no < n; no += TN) begin
      for (int ko = 0; ko < k; ko += TK) begin
        d.ksize  = 5'((k - ko) < TK ? k - ko : TK);
        d.nsize  = 5'((n - no) < TN ? n - no : TN);
        d.k_off  = 16'(ko);
        d.n_off  = 16'(no);
        d.k_last = (k - ko) <= TK;
        d.n_last = (n - no) <= TN;
        sb.push_back(d);
      end
    end
  endfunction

  // Scoreboard: every transfer pops one expected descriptor.
  always @(negedge clk) begin
    tile_desc_t g, e;
    if (!rst && tile_valid && tile_ready) begin
      g = '{ksize, nsize, k_off, n_off, k_last, n_last};
      checks++;
      n_xfer++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got ks=%0d ns=%0d ko=%0d no=%0d, expected none",
                 g.ksize, g.nsize, g.k_off, g.n_off);
      end else begin
        e = sb.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL sb_tile: got ks=%0d ns=%0d ko=%0d no=%0d kl=%0d nl=%0d, expected ks=%0d ns=%0d ko=%0d no=%0d kl=%0d nl=%0d",
                   g.ksize, g.nsize, g.k_off, g.n_off, g.k_last, g.n_last,
                   e.ksize, e.nsize, e.k_off, e.n_off, e.k_last, e.n_last);
        end
      end
    end
  end

  // Runs one job to completion and reports what it observed.
  task automatic drive_job(input int k, input int n, input int mode,
                           input int pulse_at, output bit first_valid,
                           output bit got_done, output int done_cyc,
                           output bit done_ok, output bit done_once,
                           output bit stable_ok, output int busy_cnt);
    tile_desc_t pd, cd;
    bit prev_fin, prev_hold;
    n_xfer = 0;
    start = 1'b1;
    k_total = 16'(k);
    n_total = 16'(n);
    tile_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k_total = 16'($urandom);
    n_total = 16'($urandom);
    first_valid = tile_valid;
    got_done = 0; done_cyc = -1; done_ok = 0; done_once = 0;
    stable_ok = 1; busy_cnt = 0; prev_fin = 0; prev_hold = 0; pd = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      cd = '{ksize, nsize, k_off, n_off, k_last, n_last};
      if (busy) busy_cnt++;
      if (done) begin
        got_done = 1; done_cyc = cyc; done_ok = prev_fin;
        break;
      end
      if (prev_hold && (!tile_valid || cd !== pd)) stable_ok = 0;
      start = (cyc == pulse_at);
      if (start) begin
        k_total = 16'd5;
        n_total = 16'd3;
      end
      tile_ready = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      prev_hold = tile_valid && !tile_ready;
      prev_fin = tile_valid && tile_ready && k_last && n_last;
      pd = cd;
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    done_once = got_done && !done && !tile_valid;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; tile_ready = 1'b0;
    k_total = '0; n_total = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, tile_valid, done, ksize, nsize, k_off, n_off, k_last, n_last} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got b=%0b v=%0b d=%0b ks=%0d ns=%0d ko=%0d no=%0d, expected all 0",
               busy, tile_valid, done, ksize, nsize, k_off, n_off);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    bit fv, gd, dok, d1, st; int dc, bc;
    sb.delete();
    push_job(40, 20);
    drive_job(40, 20, 0, -1, fv, gd, dc, dok, d1, st, bc);
    checks++;
    if (fv !== 1'b1) begin errors++; $display("FAIL basic_first_valid: got %0b, expected 1", fv); end
    checks++;
    if (n_xfer != 6) begin errors++; $display("FAIL basic_count: got %0d, expected 6", n_xfer); end
    checks++;
    if (!(gd && dok)) begin errors++; $display("FAIL basic_done_timing: got done=%0b after_last=%0b, expected 1/1", gd, dok); end
    checks++;
    if (dc != 6) begin errors++; $display("FAIL basic_back_to_back: done at cycle %0d, expected 6", dc); end
    checks++;
    if (!d1) begin errors++; $display("FAIL basic_done_pulse: got lingering done/valid, expected one-cycle pulse"); end
    checks++;
    if (bc != 6) begin errors++; $display("FAIL basic_busy: got %0d busy cycles, expected 6", bc); end
  endtask

  task automatic test_exact;
    bit fv, gd, dok, d1, st; int dc, bc;
    sb.delete();
    push_job(32, 16);
    drive_job(32, 16, 0, -1, fv, gd, dc, dok, d1, st, bc);
    checks++;
    if (n_xfer != 2) begin errors++; $display("FAIL exact_count: got %0d, expected 2", n_xfer); end
    checks++;
    if (!(gd && dok && d1)) begin errors++; $display("FAIL exact_done: got done=%0b ok=%0b once=%0b, expected 1/1/1", gd, dok, d1); end
  endtask

  task automatic test_stall;
    bit fv, gd, dok, d1, st; int dc, bc;
    sb.delete();
    push_job(40, 20);
    drive_job(40, 20, 1, -1, fv, gd, dc, dok, d1, st, bc);
    checks++;
    if (!st) begin errors++; $display("FAIL stall_stable: got descriptor change during stall, expected stable"); end
    checks++;
    if (n_xfer != 6) begin errors++; $display("FAIL stall_count: got %0d, expected 6", n_xfer); end
    checks++;
    if (!(gd && dok)) begin errors++; $display("FAIL stall_done: got done=%0b ok=%0b, expected 1/1", gd, dok); end
  endtask

  task automatic test_zero;
    bit fv, gd, dok, d1, st; int dc, bc;
    sb.delete();
    drive_job(0, 8, 0, -1, fv, gd, dc, dok, d1, st, bc);
    checks++;
    if (!(gd && dc == 0)) begin errors++; $display("FAIL zero_done: got done=%0b at cycle %0d, expected 1 at 0", gd, dc); end
    checks++;
    if (n_xfer != 0 || fv) begin errors++; $display("FAIL zero_tiles: got %0d tiles valid=%0b, expected 0/0", n_xfer, fv); end
    checks++;
    if (bc != 0) begin errors++; $display("FAIL zero_busy: got %0d busy cycles, expected 0", bc); end
    checks++;
    if (!d1) begin errors++; $display("FAIL zero_pulse: got lingering done, expected one-cycle pulse"); end
  endtask

  task automatic test_restart_ignored;
    bit fv, gd, dok, d1, st; int dc, bc;
    sb.delete();
    push_job(40, 20);
    drive_job(40, 20, 0, 2, fv, gd, dc, dok, d1, st, bc);
    checks++;
    if (n_xfer != 6 || sb.size() != 0) begin errors++; $display("FAIL restart_count: got %0d tiles %0d left, expected 6/0", n_xfer, sb.size()); end
    checks++;
    if (!(gd && dok && d1)) begin errors++; $display("FAIL restart_done: got done=%0b ok=%0b once=%0b, expected 1/1/1", gd, dok, d1); end
  endtask

  task automatic test_rst_mid;
    bit fv, gd, dok, d1, st, hit, bad; int dc, bc;
    sb.delete();
    push_job(40, 20);
    start = 1'b1; k_total = 16'd40; n_total = 16'd20; tile_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 10; i++) begin
      if (tile_valid && k_off == 16'd32) begin hit = 1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rst_third_tile: got no third tile in 10 cycles, expected one"); end
    rst = 1'b1; tile_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, tile_valid, done, ksize, nsize, k_off, n_off, k_last, n_last} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got b=%0b v=%0b d=%0b ks=%0d ko=%0d, expected all 0",
               busy, tile_valid, done, ksize, k_off);
    end
    rst = 1'b0;
    sb.delete();
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done || tile_valid || busy) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rst_no_done: got activity after reset, expected idle"); end
    push_job(5, 3);
    drive_job(5, 3, 0, -1, fv, gd, dc, dok, d1, st, bc);
    checks++;
    if (n_xfer != 1 || !(gd && dok && d1)) begin
      errors++;
      $display("FAIL rst_new_job: got %0d tiles done=%0b ok=%0b, expected 1/1/1", n_xfer, gd, dok);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_exact();
    test_stall();
    test_zero();
    test_restart_ignored();
    test_rst_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
